// File: rtl/conv_pkg.sv
// conv_pkg: K=3 rate-1/2 code constants and frame FSM state type,
// shared by the frame transmitter and the Viterbi decoder.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL
    } state_t;

    localparam int K        = 3;
    localparam int TAIL_LEN = 2;

    localparam logic [K-1:0] G0_DEF = 3'b111;
    localparam logic [K-1:0] G1_DEF = 3'b101;

    function automatic logic parity(input logic [K-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational K=3 encoder step, producing one 2-bit
// symbol and the next shift-register state from the current state and input bit.
module conv_enc_core
    import conv_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic         i_b,
    input  logic [K-2:0] i_sr,
    output logic [1:0]   o_sym,
    output logic [K-2:0] o_sr_nxt
);

    logic [K-1:0] w_taps;

    assign w_taps   = {i_b, i_sr};
    assign o_sym    = {parity(G0 & w_taps), parity(G1 & w_taps)};
    assign o_sr_nxt = w_taps[K-1:1];

endmodule

// File: rtl/conv_frame_tx.sv
// conv_frame_tx: frames a bit stream into FRAME_LEN data symbols plus
// TAIL_LEN zero-flush symbols through a registered valid/ready output stage.
module conv_frame_tx
    import conv_pkg::*;
#(
    parameter int           FRAME_LEN = 256,
    parameter logic [K-1:0] G0        = G0_DEF,
    parameter logic [K-1:0] G1        = G1_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    output logic [1:0]  out_sym,
    output logic        out_sof,
    output logic        out_eof,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] frame_ct
);

    localparam int          TAIL_W = $clog2(TAIL_LEN);
    localparam logic [15:0] LEN    = 16'(FRAME_LEN);

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_bit_cnt, w_bit_cnt_nxt;
    logic [TAIL_W-1:0]   r_tail_idx, w_tail_idx_nxt;
    logic [K-2:0]        r_sr, w_sr_nxt;
    logic                r_out_valid, r_out_sof, r_out_eof;
    logic [1:0]          r_out_sym, w_sym;
    logic [15:0]         r_frame_ct, w_cnt_inc;
    logic                w_free, w_acc, w_tail_ld, w_last_tail, w_last_bit, w_b;

    assign w_free      = !r_out_valid || out_ready;
    assign in_ready    = !rst && r_state != ST_TAIL && w_free;
    assign w_acc       = in_valid && in_ready;
    assign w_tail_ld   = !rst && r_state == ST_TAIL && w_free;
    assign w_last_tail = r_tail_idx == TAIL_W'(TAIL_LEN - 1);
    assign w_cnt_inc   = r_state == ST_IDLE ? 16'd1 : r_bit_cnt + 16'd1;
    assign w_last_bit  = w_cnt_inc == LEN;
    // Tail symbols flush the encoder with zeros so every frame ends in sr=00.
    assign w_b         = r_state != ST_TAIL && in_bit;

    conv_enc_core #(
        .G0(G0),
        .G1(G1)
    ) u_core (
        .i_b     (w_b),
        .i_sr    (r_sr),
        .o_sym   (w_sym),
        .o_sr_nxt(w_sr_nxt)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tail_idx_nxt = r_tail_idx;
        if (w_acc) begin
            w_bit_cnt_nxt = w_cnt_inc;
            w_state_nxt   = w_last_bit ? ST_TAIL : ST_DATA;
        end else if (w_tail_ld) begin
            w_tail_idx_nxt = w_last_tail ? '0 : r_tail_idx + 1'b1;
            w_state_nxt    = w_last_tail ? ST_IDLE : ST_TAIL;
            w_bit_cnt_nxt  = w_last_tail ? '0 : r_bit_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_tail_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tail_idx <= w_tail_idx_nxt;
        end
    end

    // A new symbol is loaded only when the output register is free, so nothing is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr        <= '0;
            r_out_valid <= 1'b0;
            r_out_sym   <= '0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_frame_ct  <= '0;
        end else begin
            if (w_acc || w_tail_ld) begin
                r_sr        <= w_sr_nxt;
                r_out_valid <= 1'b1;
                r_out_sym   <= w_sym;
                r_out_sof   <= w_acc && r_state == ST_IDLE;
                r_out_eof   <= w_tail_ld && w_last_tail;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_sym   <= '0;
                r_out_sof   <= 1'b0;
                r_out_eof   <= 1'b0;
            end
            if (r_out_valid && out_ready && r_out_eof)
                r_frame_ct <= r_frame_ct + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sym   = r_out_sym;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign busy      = r_state != ST_IDLE;
    assign frame_ct  = r_frame_ct;

    a_hold: assert property (@(posedge clk) disable iff (rst)
        r_out_valid && !out_ready |=> r_out_valid && $stable(r_out_sym) && $stable(r_out_sof) && $stable(r_out_eof));
    a_sof_eof: assert property (@(posedge clk) !(r_out_sof && r_out_eof));

endmodule

// File: tb/tb_conv_frame_tx.sv
// tb_conv_frame_tx: table-driven cycle vectors on a FRAME_LEN=4 encoder plus
// hand-written sequences for counter wrap and a FRAME_LEN=1 encoder.
module tb_conv_frame_tx;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic        ib;
        logic        ordy;
        logic        ov;
        logic [1:0]  sym;
        logic        sof;
        logic        eof;
        logic        ir;
        logic        bz;
        logic [15:0] fct;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_sof, out_eof, busy;
    logic [1:0]  out_sym;
    logic [15:0] frame_ct;
    logic        iv1 = 1'b0, ib1 = 1'b0;
    logic        ir1, ov1, sof1, eof1, busy1;
    logic [1:0]  sym1;
    logic [15:0] fct1;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    conv_frame_tx #(.FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .out_valid(out_valid), .out_sym(out_sym), .out_sof(out_sof), .out_eof(out_eof),
        .out_ready(out_ready), .busy(busy), .frame_ct(frame_ct)
    );

    conv_frame_tx #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_bit(ib1), .in_ready(ir1),
        .out_valid(ov1), .out_sym(sym1), .out_sof(sof1), .out_eof(eof1),
        .out_ready(out_ready), .busy(busy1), .frame_ct(fct1)
    );

    task automatic add(input logic r, iv, ib, ordy, ov, input logic [1:0] sym,
                       input logic sof, eof, ir, bz, input logic [15:0] fct);
        vec_t v;
        v.rst = r; v.iv = iv; v.ib = ib; v.ordy = ordy; v.ov = ov; v.sym = sym;
        v.sof = sof; v.eof = eof; v.ir = ir; v.bz = bz; v.fct = fct;
        vq.push_back(v);
    endtask

    // bits 1,0,1,1 -> 11,10,00,01,01,11 with out_ready=1
    task automatic add_frame(input logic [15:0] b);
        add(0, 1, 1, 1,  0, 2'b00, 0, 0, 1, 0, b);
        add(0, 1, 0, 1,  1, 2'b11, 1, 0, 1, 1, b);
        add(0, 1, 1, 1,  1, 2'b10, 0, 0, 1, 1, b);
        add(0, 1, 1, 1,  1, 2'b00, 0, 0, 1, 1, b);
        add(0, 0, 0, 1,  1, 2'b01, 0, 0, 0, 1, b);
        add(0, 0, 0, 1,  1, 2'b01, 0, 0, 0, 1, b);
        add(0, 0, 0, 1,  1, 2'b11, 0, 1, 1, 0, b);
        add(0, 0, 0, 1,  0, 2'b00, 0, 0, 1, 0, b + 16'd1);
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        rst = v.rst; in_valid = v.iv; in_bit = v.ib; out_ready = v.ordy;
        #1;
        n_vec++;
        if ({out_valid, out_sym, out_sof, out_eof, in_ready, busy, frame_ct} !==
            {v.ov, v.sym, v.sof, v.eof, v.ir, v.bz, v.fct}) begin
            n_bad++;
            $display("FAIL vec%0d: got v=%b sym=%b sof=%b eof=%b ir=%b busy=%b fct=%0d, expected v=%b sym=%b sof=%b eof=%b ir=%b busy=%b fct=%0d",
                     idx, out_valid, out_sym, out_sof, out_eof, in_ready, busy, frame_ct,
                     v.ov, v.sym, v.sof, v.eof, v.ir, v.bz, v.fct);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] e_sym[3];
        logic       e_sof[3];
        logic       e_eof[3];
        logic [3:0] bits;
        e_sym = '{2'b11, 2'b10, 2'b11};
        e_sof = '{1'b1, 1'b0, 1'b0};
        e_eof = '{1'b0, 1'b0, 1'b1};
        bits  = 4'b1101;
        // reset state, then single frame
        add(1, 0, 0, 1,  0, 2'b00, 0, 0, 0, 0, 16'd0);
        add_frame(16'd0);
        // stall three cycles on the second symbol
        add(0, 1, 1, 1,  0, 2'b00, 0, 0, 1, 0, 16'd1);
        add(0, 1, 0, 1,  1, 2'b11, 1, 0, 1, 1, 16'd1);
        add(0, 1, 1, 0,  1, 2'b10, 0, 0, 0, 1, 16'd1);
        add(0, 1, 1, 0,  1, 2'b10, 0, 0, 0, 1, 16'd1);
        add(0, 1, 1, 0,  1, 2'b10, 0, 0, 0, 1, 16'd1);
        add(0, 1, 1, 1,  1, 2'b10, 0, 0, 1, 1, 16'd1);
        add(0, 1, 1, 1,  1, 2'b00, 0, 0, 1, 1, 16'd1);
        add(0, 0, 0, 1,  1, 2'b01, 0, 0, 0, 1, 16'd1);
        add(0, 0, 0, 1,  1, 2'b01, 0, 0, 0, 1, 16'd1);
        add(0, 0, 0, 1,  1, 2'b11, 0, 1, 1, 0, 16'd1);
        add(0, 0, 0, 1,  0, 2'b00, 0, 0, 1, 0, 16'd2);
        // reset after two bits, then a fresh frame
        add(0, 1, 1, 1,  0, 2'b00, 0, 0, 1, 0, 16'd2);
        add(0, 1, 0, 1,  1, 2'b11, 1, 0, 1, 1, 16'd2);
        add(1, 0, 0, 1,  1, 2'b10, 0, 0, 0, 1, 16'd2);
        add(0, 0, 0, 1,  0, 2'b00, 0, 0, 1, 0, 16'd0);
        add_frame(16'd0);
        // back-to-back frames after reset
        add(1, 0, 0, 1,  0, 2'b00, 0, 0, 0, 0, 16'd1);
        add(0, 1, 1, 1,  0, 2'b00, 0, 0, 1, 0, 16'd0);
        add(0, 1, 0, 1,  1, 2'b11, 1, 0, 1, 1, 16'd0);
        add(0, 1, 1, 1,  1, 2'b10, 0, 0, 1, 1, 16'd0);
        add(0, 1, 1, 1,  1, 2'b00, 0, 0, 1, 1, 16'd0);
        add(0, 1, 1, 1,  1, 2'b01, 0, 0, 0, 1, 16'd0);
        add(0, 1, 1, 1,  1, 2'b01, 0, 0, 0, 1, 16'd0);
        add(0, 1, 1, 1,  1, 2'b11, 0, 1, 1, 0, 16'd0);
        add(0, 1, 0, 1,  1, 2'b11, 1, 0, 1, 1, 16'd1);
        add(0, 1, 1, 1,  1, 2'b10, 0, 0, 1, 1, 16'd1);
        add(0, 1, 1, 1,  1, 2'b00, 0, 0, 1, 1, 16'd1);
        add(0, 0, 0, 1,  1, 2'b01, 0, 0, 0, 1, 16'd1);
        add(0, 0, 0, 1,  1, 2'b01, 0, 0, 0, 1, 16'd1);
        add(0, 0, 0, 1,  1, 2'b11, 0, 1, 1, 0, 16'd1);
        add(0, 0, 0, 1,  0, 2'b00, 0, 0, 1, 0, 16'd2);

        repeat (2) @(negedge clk);
        foreach (vq[i]) apply(i, vq[i]);

        // frame counter wrap
        @(negedge clk);
        force dut.r_frame_ct = 16'hffff;
        #1;
        release dut.r_frame_ct;
        @(negedge clk);
        check("fct_forced", 32'(frame_ct), 32'hffff);
        for (int i = 3; i >= 0; i--) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !(out_valid && out_eof); i++) @(negedge clk);
        check("wrap_eof_seen", 32'(out_valid && out_eof), 32'd1);
        @(negedge clk);
        check("fct_wrap", 32'(frame_ct), 32'd0);

        // FRAME_LEN=1 encoder
        @(negedge clk);
        iv1 = 1'b1;
        ib1 = 1'b1;
        #1;
        check("len1_ready", 32'(ir1), 32'd1);
        @(negedge clk);
        iv1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("len1_sym%0d", k), {27'd0, ov1, sym1, sof1, eof1},
                  {27'd0, 1'b1, e_sym[k], e_sof[k], e_eof[k]});
            check($sformatf("len1_excl%0d", k), 32'(sof1 && eof1), 32'd0);
            if (k == 0) check("len1_tail_ready", 32'(ir1), 32'd0);
            @(negedge clk);
        end
        #1;
        check("len1_idle", {30'd0, ov1, busy1}, 32'd0);
        check("len1_fct", 32'(fct1), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
